// File: rtl/msg_pkg.sv
// Shared definitions for the message queue.
//   tx_state_t  : transmit FSM states (IDLE, SEND, GAP)
//   MSG_DATA_W  : default element width
//   MSG_DEPTH   : default queue depth (power of two, >= 2)
package msg_pkg;

  localparam int MSG_DATA_W = 8;
  localparam int MSG_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/msg_queue_edge_detect.sv
// Rising-edge detector for the producer strobe.
//   clk  : system clock
//   nRst : asynchronous active-low reset
//   in   : level input
//   rise : high for the cycle in which in is 1 and was 0 on the previous edge
// The delayed copy resets to 0, so an input already high when reset releases
// is seen as a rising edge on the first clock.
module edge_detect (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  output logic rise
);

  logic r_in_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_in_q <= 1'b0;
    end else begin
      r_in_q <= in;
    end
  end

  assign rise = in & ~r_in_q;

endmodule

// File: rtl/msg_queue.sv
// Message queue: a small circular buffer filled by a strobed producer and
// drained one element per transmit_ready high period by a transmit FSM.
//
// Ports
//   clk, nRst       : clock, asynchronous active-low reset
//   ready, data     : producer strobe (rising edge pushes) and element
//   transmit_ready  : transmitter can take one element while high
//   tx_ctrl         : one-cycle strobe qualifying tx_byte
//   tx_byte         : element being sent (registered, held until next pop)
//   blue            : message-pending indicator (queue non-empty)
//   full, empty     : queue status
//   count           : occupancy 0..DEPTH
//   overflow        : sticky dropped-push flag (only with
//                     MSG_QUEUE_OVERFLOW_FLAG_EN defined)
//   o_dbg_state     : current transmit FSM state
//
// Handshake: a push is the rising edge of ready; it is accepted when the
// queue is not full, or when it is full and a pop happens on the same edge.
// A pop happens on the edge where the FSM is IDLE, transmit_ready is high and
// the queue is non-empty; tx_ctrl is then high for the following cycle.
module msg_queue
  import msg_pkg::*;
#(
  parameter int DATA_W = MSG_DATA_W,
  parameter int DEPTH  = MSG_DEPTH
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic                       ready,
  input  logic [DATA_W-1:0]          data,
  input  logic                       transmit_ready,
  output logic                       tx_ctrl,
  output logic [DATA_W-1:0]          tx_byte,
  output logic                       blue,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
  output logic                       overflow,
`endif
  output tx_state_t                  o_dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_tx_byte;
  tx_state_t         r_state;
  tx_state_t         w_next_state;

  logic w_push;
  logic w_pop;
  logic w_wr_en;
  logic w_full;
  logic w_empty;

  edge_detect u_edge (
    .clk  (clk),
    .nRst (nRst),
    .in   (ready),
    .rise (w_push)
  );

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // When full, the pop frees the head slot, which is exactly where the write
  // pointer sits, so the simultaneous push lands safely behind the new head.
  assign w_wr_en = w_push & (~w_full | w_pop);

  // Transmit FSM: next state, pop decision and tx_ctrl strobe.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    tx_ctrl      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (transmit_ready && !w_empty) begin
          w_pop        = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        tx_ctrl      = 1'b1;
        w_next_state = transmit_ready ? GAP : IDLE;
      end
      GAP: begin
        // Wait for transmit_ready to drop so one high period sends one element.
        if (!transmit_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Element storage needs no reset: only slots covered by count are visible.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_byte <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_byte <= r_mem[r_rd_ptr];
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  assign tx_byte     = r_tx_byte;
  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign blue        = ~w_empty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msg_queue.sv
// Self-checking bench for msg_queue: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// queue-based reference model.
module tb_msg_queue;
  import msg_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nRst = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] data = '0;
  logic          transmit_ready = 1'b0;
  logic          tx_ctrl;
  logic [DW-1:0] tx_byte;
  logic          blue, full, empty;
  logic [$clog2(DEPTH):0] count;
  tx_state_t     dbg_state;
`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  msg_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .nRst           (nRst),
    .ready          (ready),
    .data           (data),
    .transmit_ready (transmit_ready),
    .tx_ctrl        (tx_ctrl),
    .tx_byte        (tx_byte),
    .blue           (blue),
    .full           (full),
    .empty          (empty),
    .count          (count),
`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
    .overflow       (overflow),
`endif
    .o_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the queued elements in order. A send is "pending" for the
  // cycle after a pop (tx_ctrl high). "blocked" means an element has been sent
  // during the current transmit_ready high period and no low has been seen.
  logic [DW-1:0] exp_q[$];
  bit            m_prev_ready = 0;
  bit            m_pend = 0;
  bit            m_blocked = 0;
  bit            m_ovf = 0;
  logic [DW-1:0] m_tx = '0;
  bit            do_pop, do_push;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      exp_q.delete();
      m_prev_ready = 0;
      m_pend       = 0;
      m_blocked    = 0;
      m_ovf        = 0;
      m_tx         = '0;
    end else begin
      do_pop    = !m_pend && !m_blocked && transmit_ready && (exp_q.size() > 0);
      do_push   = ready && !m_prev_ready;
      m_blocked = (m_pend || m_blocked) && transmit_ready;
      m_pend    = do_pop;
      if (do_pop) m_tx = exp_q.pop_front();
      if (do_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(data);
        else m_ovf = 1;
      end
      m_prev_ready = ready;
    end
  end

  function automatic int exp_state();
    if (m_pend) return int'(SEND);
    if (m_blocked) return int'(GAP);
    return int'(IDLE);
  endfunction

  // Every-cycle comparison, on the falling edge.
  always @(negedge clk) begin
    check("m_count",   int'(count),   exp_q.size());
    check("m_empty",   int'(empty),   int'(exp_q.size() == 0));
    check("m_full",    int'(full),    int'(exp_q.size() == DEPTH));
    check("m_blue",    int'(blue),    int'(exp_q.size() != 0));
    check("m_tx_ctrl", int'(tx_ctrl), int'(m_pend));
    check("m_tx_byte", int'(tx_byte), int'(m_tx));
    check("m_state",   int'(dbg_state), exp_state());
`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
    check("m_overflow", int'(overflow), int'(m_ovf));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    data  = d;
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
  endtask

  // One transmit_ready pulse: high for one edge (pop), then low.
  task automatic pulse_send(input string name, input logic [DW-1:0] exp_b,
                            input int exp_cnt);
    transmit_ready = 1'b1;
    step();
    check({name, "_ctrl"},  int'(tx_ctrl), 1);
    check({name, "_byte"},  int'(tx_byte), int'(exp_b));
    check({name, "_count"}, int'(count), exp_cnt);
    transmit_ready = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  int pulses;

  initial begin
    // Reset state, with ready held high across the release.
    nRst  = 1'b0;
    ready = 1'b1;
    data  = 8'h05;
    step();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full), 0);
    check("rst_blue",  int'(blue), 0);
    check("rst_ctrl",  int'(tx_ctrl), 0);
    check("rst_byte",  int'(tx_byte), 0);
    nRst = 1'b1;
    step();
    check("rel_count", int'(count), 1);
    check("rel_blue",  int'(blue), 1);
    check("rel_ctrl",  int'(tx_ctrl), 0);

    // Single send with transmit_ready held high for 3 edges.
    ready = 1'b0;
    transmit_ready = 1'b1;
    pulses = 0;
    step();
    check("single_byte", int'(tx_byte), 8'h05);
    check("single_empty", int'(empty), 1);
    if (tx_ctrl) pulses++;
    step();
    if (tx_ctrl) pulses++;
    step();
    if (tx_ctrl) pulses++;
    check("single_pulses", pulses, 1);
    check("single_gap",  int'(dbg_state), int'(GAP));
    check("single_blue", int'(blue), 0);
    transmit_ready = 1'b0;
    step();
    check("single_idle", int'(dbg_state), int'(IDLE));

    // Order test.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("order_count", int'(count), 3);
    pulse_send("order0", 8'h11, 2);
    pulse_send("order1", 8'h22, 1);
    pulse_send("order2", 8'h33, 0);

    // Full test: fifth push dropped.
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    push(8'hA5);
    check("full_flag",  int'(full), 1);
    check("full_count", int'(count), 4);
`ifdef MSG_QUEUE_OVERFLOW_FLAG_EN
    check("full_ovf", int'(overflow), 1);
`endif

    // Simultaneous push and pop at full.
    data           = 8'hB0;
    ready          = 1'b1;
    transmit_ready = 1'b1;
    step();
    check("simul_count", int'(count), 4);
    check("simul_byte",  int'(tx_byte), 8'hA1);
    ready          = 1'b0;
    transmit_ready = 1'b0;
    step();
    pulse_send("drain0", 8'hA2, 3);
    pulse_send("drain1", 8'hA3, 2);
    pulse_send("drain2", 8'hA4, 1);
    pulse_send("drain3", 8'hB0, 0);

    // Reset during SEND.
    push(8'h77);
    transmit_ready = 1'b1;
    step();
    check("mid_send", int'(tx_ctrl), 1);
    nRst = 1'b0;
    #1;
    check("mid_ctrl",  int'(tx_ctrl), 0);
    check("mid_count", int'(count), 0);
    check("mid_empty", int'(empty), 1);
    #2;
    nRst = 1'b1;
    pulses = 0;
    repeat (4) begin
      step();
      if (tx_ctrl) pulses++;
    end
    check("mid_quiet", pulses, 0);
    transmit_ready = 1'b0;
    step();
    push(8'h3C);
    pulse_send("mid_resume", 8'h3C, 0);

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        nRst = 1'b0;
        step();
        nRst = 1'b1;
      end
      ready = ($urandom_range(0, 1) == 1);
      data  = DW'($urandom_range(0, 255));
      if (((i / 150) % 2) == 0)
        transmit_ready = ($urandom_range(0, 99) < 15);
      else
        transmit_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    ready          = 1'b0;
    transmit_ready = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_queue.md
MSG_QUEUE -- requirements
Module: msg_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one message element.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; legal values are powers of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port nRst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port ready, input, 1: producer strobe; its rising edge pushes data.
REQ-006 SHALL have port data, input, DATA_W: element to push.
REQ-007 SHALL have port transmit_ready, input, 1: level from the transmitter; high means it can accept one byte.
REQ-008 SHALL have port tx_ctrl, output, 1: one-cycle send strobe qualifying tx_byte.
REQ-009 SHALL have port tx_byte, output, DATA_W: element being sent, registered.
REQ-010 SHALL have port blue, output, 1: message-pending indicator, high while the queue is non-empty.
REQ-011 SHALL have ports full and empty, output, 1 each: queue status.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

Function
REQ-013 SHALL detect push as ready & ~ready_q, where ready_q is ready registered one cycle; a level held high pushes exactly once.
REQ-014 SHALL write data at the tail on a push cycle when not full; the element is countable and poppable from the next cycle.
REQ-015 SHALL drop a push when full with no pop in the same cycle; count and contents SHALL be unchanged.
REQ-016 SHALL accept a push when full and a pop occur in the same cycle; count stays DEPTH.
REQ-017 SHALL keep count unchanged when push and pop occur together at any other occupancy.
REQ-018 SHALL use wrap-around read/write pointers of $clog2(DEPTH) bits; full = (count==DEPTH), empty = (count==0).
REQ-019 SHALL run a transmit FSM with states IDLE, SEND, GAP.
REQ-020 IDLE: if transmit_ready & ~empty, pop head into tx_byte, go SEND; otherwise stay.
REQ-021 SEND: tx_ctrl=1 for exactly this cycle; go GAP if transmit_ready is high, else IDLE.
REQ-022 GAP: tx_ctrl=0; return to IDLE only after transmit_ready is sampled low, so each transmit_ready high period sends at most one element.
REQ-023 SHALL drive tx_ctrl low outside SEND; tx_byte SHALL hold its last value until the next pop.
REQ-024 SHALL not pop and SHALL not assert tx_ctrl while empty, regardless of transmit_ready.
REQ-025 Latency: transmit_ready is sampled high in IDLE with the queue non-empty at edge N; tx_ctrl SHALL be high in cycle N+1.

Reset
REQ-026 On nRst low, immediately: pointers, count, ready_q = 0; state = IDLE; tx_ctrl = 0; tx_byte = 0; blue = 0; empty = 1; full = 0.
REQ-027 Reset mid-SEND or mid-GAP SHALL abort the transfer and discard all queued elements.
REQ-028 If ready is high when nRst deasserts, a push SHALL occur on the first clock edge.

Configuration
REQ-029 With MSG_QUEUE_OVERFLOW_FLAG_EN defined: output overflow (1 bit) is added, reset 0, set sticky on any dropped push, cleared only by reset.
REQ-030 Without MSG_QUEUE_OVERFLOW_FLAG_EN: no overflow port; drops are silent; all other behaviour is identical.

Structure
REQ-031 Package msg_pkg SHALL hold the tx_state_t enum (IDLE, SEND, GAP) and the default constants MSG_DATA_W=8 and MSG_DEPTH=4.
REQ-032 Sub-module edge_detect (clk, nRst, in, rise) SHALL implement REQ-013; storage and the FSM SHALL stay in msg_queue.

Verification
REQ-033 Reset test: hold ready=1 across nRst release with data=8'h05 -> count=1 after the first edge, blue=1, tx_ctrl=0.
REQ-034 Single send test: push 8'h05, then raise transmit_ready and hold it high for 3 cycles -> exactly one tx_ctrl pulse with tx_byte=8'h05, after which empty=1, blue=0, and the FSM stays in GAP until transmit_ready falls.
REQ-035 Order test: push 8'h11, 8'h22, 8'h33, then pulse transmit_ready three times -> tx_byte sequence 11, 22, 33 and count 3->0.
REQ-036 Full test at DEPTH=4: push 5 elements (A1..A5) -> full=1, count=4, A5 dropped, overflow=1 if the macro is defined; draining yields A1..A4.
REQ-037 Simultaneous test: at full, push B0 on the same edge IDLE pops -> count stays 4 and B0 is the last element drained.
REQ-038 Mid-operation reset test: assert nRst during SEND -> tx_ctrl=0, count=0, empty=1 immediately; no further tx_ctrl until a new push occurs.
